uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Packet-level UART transmitter, 8N1 framing, LSB first.
- Accepts a packet of DEPTH bytes in one valid/ready handshake and serialises the bytes back-to-back on the single tx line at the configured baud rate.
- Sits between a byte-packet producer (e.g. FFT result formatter) and the board UART pin.
- Whole packet is captured at acceptance, so upstream may change data_i while transmission is in progress.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- boadrate, 115200, line baud rate in bit/s.
- DEPTH, 8, bytes per packet (>=1).
- Derived constant BIT_CYCLES = CLK_FREQ/boadrate, integer division truncating. Default is 434.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- arstn  input  1  reset, synchronous, active-low.
- tx  output  1  serial line, idle high.
- data_i  input  DEPTH x 8 (packed [DEPTH-1:0][7:0])  packet bytes; byte index 0 is sent first.
- up_valid  input  1  upstream asserts when data_i holds a packet.
- up_ready  output  1  high when the block can accept a packet.

Behaviour:
- Reset: while arstn=0 at a clk edge, the following values are forced:
  - state=IDLE, tx=1, up_ready=0, all counters 0.
  - up_ready=1 from the first edge with arstn=1.
- Reset asserted mid-packet aborts the packet at the next edge: tx=1, and the remaining bytes are discarded.
- Handshake: acceptance happens on an edge with up_valid=1 and up_ready=1.
  - On acceptance, all DEPTH bytes are registered into a shift/packet register and up_ready goes to 0.
  - up_ready stays 0 until the packet completes.
  - up_valid while busy is ignored.
  - up_valid may drop at any time without effect.
- States:
  - IDLE: tx=1, up_ready=1.
  - START: tx=0.
  - DATA: tx = current byte bit k, k=0..7 (LSB first).
  - STOP: tx=1.
- Each state bit lasts exactly BIT_CYCLES clocks, counted by a baud counter that resets at every bit boundary.
- Transitions:
  - IDLE -> START on acceptance. tx drives 0 starting the edge after the accepting edge, i.e. latency 1 cycle.
  - START -> DATA.
  - DATA -> DATA 8 times, then DATA -> STOP.
  - STOP -> START of the next byte (byte index +1) when bytes remain. No idle gap between frames.
  - STOP of byte DEPTH-1 -> IDLE. up_ready=1 on the edge ending that stop bit.
- Back-to-back packets: if up_valid=1 when up_ready returns to 1, the next packet is accepted on that edge. The only gap beyond the stop bit is 1 cycle (the IDLE cycle).
- Timing: frame = 10*BIT_CYCLES clocks (4340 at default). Packet = DEPTH*10*BIT_CYCLES clocks (34720 at default).
- Outputs are registered; tx has no combinational path from inputs.
- Counter widths: $clog2(BIT_CYCLES), 3-bit bit index, $clog2(DEPTH)+1 byte index.

Test Plan:
- Reset with arstn=0 for 3 cycles -> tx=1 and up_ready=0 during reset; up_ready=1 on the first cycle after release; tx stays 1 with no stimulus.
- Send one packet, data_i = {32'h01020304, 32'h10203040} with up_valid pulsed for 1 cycle:
  - up_ready falls the next cycle.
  - Decoded tx bytes are 40,30,20,10,04,03,02,01.
  - Each bit is 434 clocks; start=0, stop=1.
  - up_ready returns to 1 exactly 34720 cycles after acceptance.
- Hold up_valid=1 and change data_i to 64'h11121314 right after the first packet starts -> the first packet is still sent unchanged. When up_ready rises, the second packet is accepted; it sends 14,13,12,11,00,00,00,00.
- Drop up_valid and continue for 12 bit periods -> tx stays 1 and up_ready stays 1 after the last stop bit.
- Assert arstn=0 in the middle of byte 3 -> tx=1 on the next edge. After release: up_ready=1, and a new packet transmits correctly from byte 0.
- Set boadrate=9600 with DEPTH=1 and send 8'hA5 -> each bit is 5208 clocks; bit sequence on tx is 0,1,0,1,0,0,1,0,1,1.

Source files
------------

// File: rtl/uart_tx.sv
// Packet UART transmitter: captures DEPTH bytes in one handshake and sends them
// back-to-back as 8N1 frames, LSB first, byte 0 first.
module uart_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int boadrate = 115200,
  parameter int DEPTH    = 8
) (
  input  logic                  clk,
  input  logic                  arstn,
  output logic                  tx,
  input  logic [DEPTH-1:0][7:0] data_i,
  input  logic                  up_valid,
  output logic                  up_ready
);

  localparam int BIT_CYCLES = CLK_FREQ / boadrate;
  localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        baud_cnt, baud_cnt_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic [BW-1:0]        byte_idx, byte_idx_n;
  logic [DEPTH*8-1:0]   pkt, pkt_n;
  logic                 tx_n, up_ready_n;
  logic                 bit_end;

  assign bit_end = (baud_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      pkt      <= '0;
      tx       <= 1'b1;
      up_ready <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      byte_idx <= byte_idx_n;
      pkt      <= pkt_n;
      tx       <= tx_n;
      up_ready <= up_ready_n;
    end
  end

  // tx_n is the line level for the cycle after this edge, keeping tx a pure flop.
  // The packet register shifts one bit per data bit, so pkt[0] is always the
  // next data bit and the following byte lines up automatically after 8 shifts.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt + CW'(1);
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    pkt_n      = pkt;
    tx_n       = tx;
    up_ready_n = up_ready;
    unique case (state)
      IDLE: begin
        baud_cnt_n = '0;
        tx_n       = 1'b1;
        up_ready_n = 1'b1;
        if (up_valid && up_ready) begin
          pkt_n      = data_i;
          byte_idx_n = '0;
          state_n    = START;
          tx_n       = 1'b0;
          up_ready_n = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = DATA;
          tx_n       = pkt[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          pkt_n      = pkt >> 1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = pkt_n[0];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          if (byte_idx == BYTE_LAST) begin
            state_n    = IDLE;
            tx_n       = 1'b1;
            up_ready_n = 1'b1;
          end else begin
            byte_idx_n = byte_idx + BW'(1);
            state_n    = START;
            tx_n       = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a fast 8-byte instance (10 clocks/bit) and a 9600-baud
// single-byte instance, both checked every cycle against a waveform-queue model.
module tb_uart_tx;

  localparam int BC_A = 10;    // 1_000_000 / 93_000 truncated
  localparam int BC_B = 5208;  // 50_000_000 / 9600 truncated

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_a, valid_a, tx_a, rdy_a;
  logic [7:0][7:0] data_a;
  logic            rst_b, valid_b, tx_b, rdy_b;
  logic [0:0][7:0] data_b;

  uart_tx #(.CLK_FREQ(1_000_000), .boadrate(93_000), .DEPTH(8)) u_a (
    .clk(clk), .arstn(rst_a), .tx(tx_a), .data_i(data_a),
    .up_valid(valid_a), .up_ready(rdy_a));

  uart_tx #(.CLK_FREQ(50_000_000), .boadrate(9600), .DEPTH(1)) u_b (
    .clk(clk), .arstn(rst_b), .tx(tx_b), .data_i(data_b),
    .up_valid(valid_b), .up_ready(rdy_b));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit b_done = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: each accepted packet becomes the exact per-cycle tx waveform in a queue;
  // the block is ready again on the first edge after the queue drains.
  bit   qa[$];
  bit   qb[$];
  logic m_tx_a, m_rdy_a, m_tx_b, m_rdy_b;
  bit   m_init = 1'b0;

  always @(posedge clk) begin
    m_init <= 1'b1;
    if (!rst_a) begin
      qa.delete(); m_tx_a <= 1'b1; m_rdy_a <= 1'b0;
    end else if (m_rdy_a && valid_a) begin
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < 10; k++)
          for (int c = 0; c < BC_A; c++)
            qa.push_back(k == 0 ? 1'b0 : (k == 9 ? 1'b1 : data_a[i][k-1]));
      m_tx_a <= qa.pop_front(); m_rdy_a <= 1'b0;
    end else if (qa.size() > 0) m_tx_a <= qa.pop_front();
    else begin m_tx_a <= 1'b1; m_rdy_a <= 1'b1; end

    if (!rst_b) begin
      qb.delete(); m_tx_b <= 1'b1; m_rdy_b <= 1'b0;
    end else if (m_rdy_b && valid_b) begin
      for (int k = 0; k < 10; k++)
        for (int c = 0; c < BC_B; c++)
          qb.push_back(k == 0 ? 1'b0 : (k == 9 ? 1'b1 : data_b[0][k-1]));
      m_tx_b <= qb.pop_front(); m_rdy_b <= 1'b0;
    end else if (qb.size() > 0) m_tx_b <= qb.pop_front();
    else begin m_tx_b <= 1'b1; m_rdy_b <= 1'b1; end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("model_a", {tx_a, rdy_a}, {m_tx_a, m_rdy_a});
      chk("model_b", {tx_b, rdy_b}, {m_tx_b, m_rdy_b});
    end
  end

  task automatic wait_rdy_a();
    int n = 0;
    while (rdy_a !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    chk("rdy_wait", rdy_a, 1);
  endtask

  // Independent line decoder: find the falling edge, sample at mid-bit.
  task automatic decode_a(output logic [7:0] b);
    int n = 0;
    b = '0;
    while (tx_a !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    chk("start_seen", tx_a, 0);
    repeat (BC_A / 2) @(negedge clk);
    chk("start_mid", tx_a, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (BC_A) @(negedge clk);
      b[i] = tx_a;
    end
    repeat (BC_A) @(negedge clk);
    chk("stop_mid", tx_a, 1);
  endtask

  task automatic decode_pkt_a(input logic [7:0][7:0] exp, input string nm);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      decode_a(b);
      chk(nm, b, exp[i]);
    end
  endtask

  initial begin
    logic [7:0][7:0] exp1, exp2, r;
    int acc, hi;
    rst_a = 1'b0; valid_a = 1'b0; data_a = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", tx_a, 1);
      chk("rst_rdy", rdy_a, 0);
    end
    rst_a = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", rdy_a, 1);
    repeat (5) @(negedge clk);
    chk("idle_tx", tx_a, 1);

    // Packet 1, valid held so packet 2 follows back-to-back with new data.
    exp1 = {32'h01020304, 32'h10203040};
    exp2 = 64'h11121314;
    data_a = exp1; valid_a = 1'b1;
    @(posedge clk); #1 acc = cyc;
    @(negedge clk);
    chk("rdy_fall", rdy_a, 0);
    data_a = exp2;
    decode_pkt_a(exp1, "pkt1_byte");
    wait_rdy_a();
    chk("pkt1_len", cyc - acc, 8 * 10 * BC_A);
    @(posedge clk); #1 acc = cyc;
    @(negedge clk);
    valid_a = 1'b0;
    chk("rdy_fall2", rdy_a, 0);
    decode_pkt_a(exp2, "pkt2_byte");
    wait_rdy_a();
    chk("pkt2_len", cyc - acc, 8 * 10 * BC_A);

    hi = 0;
    repeat (12 * BC_A) begin @(negedge clk); if (tx_a === 1'b1 && rdy_a === 1'b1) hi++; end
    chk("idle_hold", hi, 12 * BC_A);

    // Reset in the middle of byte 3, data bit 4 forced low so the abort is visible.
    r = {$urandom, $urandom};
    r[3] = r[3] & 8'hEF;
    data_a = r; valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    repeat (350) @(negedge clk);
    chk("mid_tx_low", tx_a, 0);
    rst_a = 1'b0;
    @(negedge clk);
    chk("abort_tx", tx_a, 1);
    chk("abort_rdy", rdy_a, 0);
    rst_a = 1'b1;
    @(negedge clk);
    chk("rdy_after_abort", rdy_a, 1);

    for (int p = 0; p < 4; p++) begin
      r = {$urandom, $urandom};
      repeat ($urandom_range(0, 20)) @(negedge clk);
      wait_rdy_a();
      data_a = r; valid_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_a = 1'b0;
      data_a = {$urandom, $urandom};
      decode_pkt_a(r, "rand_byte");
    end
    wait_rdy_a();

    hi = 0;
    while (!b_done && hi < 60000) begin @(negedge clk); hi++; end
    chk("b_done", b_done, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Slow single-byte instance runs alongside the fast one.
  initial begin
    bit [9:0] seq;
    int low, n;
    rst_b = 1'b0; valid_b = 1'b0; data_b = '0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("b_rdy", rdy_b, 1);
    data_b[0] = 8'hA5; valid_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_b = 1'b0;
    chk("b_rdy_fall", rdy_b, 0);
    seq = '0; low = 0;
    for (int t = 0; t < 10 * BC_B; t++) begin
      if (t % BC_B == BC_B / 2) seq[t / BC_B] = tx_b;
      if (t < BC_B + 100 && tx_b === 1'b0) low++;
      @(negedge clk);
    end
    chk("b_start_len", low, 5208);
    chk("b_bits", seq, 10'b1101001010);
    n = 0;
    while (rdy_b !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("b_rdy_back", rdy_b, 1);
    b_done = 1'b1;
  end

endmodule
